// File: rtl/timer_mode_controller.sv
// rtl/timer_mode_controller.sv - button conditioning and mode/timer/stopwatch/alarm sequencing
//
// Purpose:
//   Turns the three raw push-buttons into single-cycle press events, tracks the
//   active display mode, and runs the countdown-timer, stopwatch/lap and alarm
//   ring sequencing. Drives registered run levels and one-cycle command strobes
//   into the counting datapath.
//
// Build option:
//   TIMER_DEBOUNCE_EN - when defined, each synchronized button passes through a
//   debounce counter (DEBOUNCE_CYCLES stable samples) before edge detection.
//   When undefined, the edge detector follows the synchronizer directly.
//
// Ports:
//   clockSignal   in   system clock, all state on its rising edge
//   resetSignal   in   synchronous active-high reset
//   modeInput     in   raw mode button (async, active-high)
//   startOrStop   in   raw start/stop button (async, active-high)
//   splitOrReset  in   raw split/reset button (async, active-high)
//   timerExpired  in   datapath countdown reached zero (level)
//   alarmMatch    in   clock equals armed alarm time (level)
//   mode          out  0 timer, 1 stopwatch, 2 clock/date, 3 set alarm
//   timerLoad, timerClear, lapStore, lapClear, clockSetLoad, alarmLoad
//                 out  one-cycle command strobes
//   timerRun, stopwatchRun, alarmArmed, ringSound
//                 out  registered levels
//   lapIndex      out  current lap slot
module timer_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int LAP_DEPTH       = 50,
  parameter int RING_CYCLES     = 6000
) (
  input  logic       clockSignal,
  input  logic       resetSignal,
  input  logic       modeInput,
  input  logic       startOrStop,
  input  logic       splitOrReset,
  input  logic       timerExpired,
  input  logic       alarmMatch,
  output logic [1:0] mode,
  output logic       timerLoad,
  output logic       timerClear,
  output logic       lapStore,
  output logic       lapClear,
  output logic       clockSetLoad,
  output logic       alarmLoad,
  output logic       timerRun,
  output logic       stopwatchRun,
  output logic       alarmArmed,
  output logic       ringSound,
  output logic [5:0] lapIndex
);

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_RUN   = 2'd1,
    T_PAUSE = 2'd2
  } timer_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } sw_state_t;

  localparam int B_MODE  = 0;
  localparam int B_START = 1;
  localparam int B_SPLIT = 2;

  localparam int              RING_W    = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_CYCLES - 1);
  localparam logic [5:0]      LAP_LAST  = 6'(LAP_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop sync -> optional debounce -> rising edge
  // ---------------------------------------------------------------------------
  logic [2:0] w_btn_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_level;
  logic [2:0] r_prev;
  logic [2:0] w_press;

  assign w_btn_raw = {splitOrReset, startOrStop, modeInput};

  always_ff @(posedge clockSignal) begin
    if (resetSignal) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_prev  <= w_level;
    end
  end

`ifdef TIMER_DEBOUNCE_EN
  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] r_db_cnt [3];
  logic [2:0]      r_db_level;

  // The accepted level only flips after DEBOUNCE_CYCLES consecutive samples
  // that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clockSignal) begin
    if (resetSignal) begin
      r_db_level <= '0;
      for (int b = 0; b < 3; b++) r_db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (r_sync2[b] == r_db_level[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] >= DB_LAST) begin
          r_db_level[b] <= r_sync2[b];
          r_db_cnt[b]   <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + DB_W'(1);
        end
      end
    end
  end

  assign w_level = r_db_level;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (DEBOUNCE_CYCLES > 0);
  assign w_level      = r_sync2;
`endif

  assign w_press = w_level & ~r_prev;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [1:0]        r_mode;
  timer_state_t      r_t_state;
  sw_state_t         r_s_state;
  logic [5:0]        r_lap_idx;
  logic              r_armed;
  logic              r_ring;
  logic [RING_W-1:0] r_ring_cnt;
  logic              r_timer_run;
  logic              r_sw_run;
  logic              r_timer_load;
  logic              r_timer_clear;
  logic              r_lap_store;
  logic              r_lap_clear;
  logic              r_clk_set;
  logic              r_alarm_load;
  logic              r_exp_q;
  logic              r_match_q;
  logic              r_match_q2;

  logic [1:0]        w_mode_nxt;
  timer_state_t      w_t_nxt;
  sw_state_t         w_s_nxt;
  logic [5:0]        w_lap_nxt;
  logic              w_armed_nxt;
  logic              w_ring_nxt;
  logic [RING_W-1:0] w_ring_cnt_nxt;
  logic              w_timer_load_nxt;
  logic              w_timer_clear_nxt;
  logic              w_lap_store_nxt;
  logic              w_lap_clear_nxt;
  logic              w_clk_set_nxt;
  logic              w_alarm_load_nxt;
  logic              w_ring_trig;

  logic w_any_press;
  logic w_do_split;
  logic w_do_start;
  logic w_do_mode;

  // While ringing a press only silences. Otherwise split beats start beats mode
  // and the losers of a same-cycle collision are dropped.
  assign w_any_press = |w_press;
  assign w_do_split  = ~r_ring & w_press[B_SPLIT];
  assign w_do_start  = ~r_ring & w_press[B_START] & ~w_press[B_SPLIT];
  assign w_do_mode   = ~r_ring & w_press[B_MODE] & ~w_press[B_START] & ~w_press[B_SPLIT];

  always_comb begin
    w_mode_nxt        = r_mode;
    w_t_nxt           = r_t_state;
    w_s_nxt           = r_s_state;
    w_lap_nxt         = r_lap_idx;
    w_armed_nxt       = r_armed;
    w_ring_nxt        = r_ring;
    w_ring_cnt_nxt    = r_ring_cnt;
    w_timer_load_nxt  = 1'b0;
    w_timer_clear_nxt = 1'b0;
    w_lap_store_nxt   = 1'b0;
    w_lap_clear_nxt   = 1'b0;
    w_clk_set_nxt     = 1'b0;
    w_alarm_load_nxt  = 1'b0;
    w_ring_trig       = 1'b0;

    // lapIndex advances the cycle after lapStore so the strobe is seen
    // together with the slot it writes.
    if (r_lap_store && (r_lap_idx < LAP_LAST)) begin
      w_lap_nxt = r_lap_idx + 6'd1;
    end

    if (w_do_split) begin
      case (r_mode)
        2'd0: begin
          w_timer_clear_nxt = 1'b1;
          w_t_nxt           = T_IDLE;
        end
        2'd1: begin
          if (r_s_state == S_RUN) begin
            w_lap_store_nxt = 1'b1;
          end else if (r_s_state == S_STOP) begin
            w_lap_clear_nxt = 1'b1;
            w_lap_nxt       = '0;
            w_s_nxt         = S_IDLE;
          end
        end
        2'd3:    w_alarm_load_nxt = 1'b1;
        default: ;
      endcase
    end else if (w_do_start) begin
      case (r_mode)
        2'd0: begin
          case (r_t_state)
            T_IDLE: begin
              w_timer_load_nxt = 1'b1;
              w_t_nxt          = T_RUN;
            end
            T_RUN:   w_t_nxt = T_PAUSE;
            default: w_t_nxt = T_RUN;
          endcase
        end
        2'd1: begin
          w_s_nxt = (r_s_state == S_RUN) ? S_STOP : S_RUN;
        end
        2'd2:    w_clk_set_nxt = 1'b1;
        default: w_armed_nxt   = ~r_armed;
      endcase
    end else if (w_do_mode) begin
      w_mode_nxt = r_mode + 2'd1;
    end

    // Expiry is mode independent and only matters while counting down.
    if ((r_t_state == T_RUN) && r_exp_q) begin
      w_t_nxt     = T_IDLE;
      w_ring_trig = 1'b1;
    end

    if (r_armed && r_match_q && !r_match_q2) begin
      w_ring_trig = 1'b1;
    end

    if (w_ring_trig) begin
      w_ring_nxt     = 1'b1;
      w_ring_cnt_nxt = RING_LOAD;
    end else if (r_ring) begin
      if (w_any_press || (r_ring_cnt == '0)) begin
        w_ring_nxt = 1'b0;
      end else begin
        w_ring_cnt_nxt = r_ring_cnt - RING_W'(1);
      end
    end
  end

  always_ff @(posedge clockSignal) begin
    if (resetSignal) begin
      r_mode        <= '0;
      r_t_state     <= T_IDLE;
      r_s_state     <= S_IDLE;
      r_lap_idx     <= '0;
      r_armed       <= 1'b0;
      r_ring        <= 1'b0;
      r_ring_cnt    <= '0;
      r_timer_run   <= 1'b0;
      r_sw_run      <= 1'b0;
      r_timer_load  <= 1'b0;
      r_timer_clear <= 1'b0;
      r_lap_store   <= 1'b0;
      r_lap_clear   <= 1'b0;
      r_clk_set     <= 1'b0;
      r_alarm_load  <= 1'b0;
      r_exp_q       <= 1'b0;
      r_match_q     <= 1'b0;
      r_match_q2    <= 1'b0;
    end else begin
      r_mode        <= w_mode_nxt;
      r_t_state     <= w_t_nxt;
      r_s_state     <= w_s_nxt;
      r_lap_idx     <= w_lap_nxt;
      r_armed       <= w_armed_nxt;
      r_ring        <= w_ring_nxt;
      r_ring_cnt    <= w_ring_cnt_nxt;
      r_timer_run   <= (w_t_nxt == T_RUN);
      r_sw_run      <= (w_s_nxt == S_RUN);
      r_timer_load  <= w_timer_load_nxt;
      r_timer_clear <= w_timer_clear_nxt;
      r_lap_store   <= w_lap_store_nxt;
      r_lap_clear   <= w_lap_clear_nxt;
      r_clk_set     <= w_clk_set_nxt;
      r_alarm_load  <= w_alarm_load_nxt;
      // One register stage on the datapath levels sets the ring latency.
      r_exp_q       <= timerExpired;
      r_match_q     <= alarmMatch;
      r_match_q2    <= r_match_q;
    end
  end

  assign mode         = r_mode;
  assign timerLoad    = r_timer_load;
  assign timerClear   = r_timer_clear;
  assign lapStore     = r_lap_store;
  assign lapClear     = r_lap_clear;
  assign clockSetLoad = r_clk_set;
  assign alarmLoad    = r_alarm_load;
  assign timerRun     = r_timer_run;
  assign stopwatchRun = r_sw_run;
  assign alarmArmed   = r_armed;
  assign ringSound    = r_ring;
  assign lapIndex     = r_lap_idx;

endmodule

// File: tb/tb_timer_mode_controller.sv
// tb/tb_timer_mode_controller.sv - self-checking bench for timer_mode_controller
module tb_timer_mode_controller;

  localparam int DB    = 2;
  localparam int LAPS  = 50;
  localparam int RINGC = 6000;
`ifdef TIMER_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  localparam int TM_IDLE = 0, TM_RUN = 1, TM_PAUSE = 2;
  localparam int SW_IDLE = 0, SW_RUN = 1, SW_STOP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_mode = 1'b0, b_start = 1'b0, b_split = 1'b0;
  logic t_exp = 1'b0, a_match = 1'b0;

  logic [1:0] mode;
  logic       timerLoad, timerClear, lapStore, lapClear, clockSetLoad, alarmLoad;
  logic       timerRun, stopwatchRun, alarmArmed, ringSound;
  logic [5:0] lapIndex;
  logic [5:0] strobes;

  int checks = 0;
  int errors = 0;
  int n_store = 0;
  int n_tload = 0;

  // behavioural model of the controller, tracked per press event
  logic [1:0] m_mode;
  int         m_timer, m_sw, m_lap, m_lap_strobe;
  logic       m_armed, m_ring;

  timer_mode_controller #(
    .DEBOUNCE_CYCLES(DB),
    .LAP_DEPTH(LAPS),
    .RING_CYCLES(RINGC)
  ) dut (
    .clockSignal(clk),
    .resetSignal(rst),
    .modeInput(b_mode),
    .startOrStop(b_start),
    .splitOrReset(b_split),
    .timerExpired(t_exp),
    .alarmMatch(a_match),
    .mode(mode),
    .timerLoad(timerLoad),
    .timerClear(timerClear),
    .lapStore(lapStore),
    .lapClear(lapClear),
    .clockSetLoad(clockSetLoad),
    .alarmLoad(alarmLoad),
    .timerRun(timerRun),
    .stopwatchRun(stopwatchRun),
    .alarmArmed(alarmArmed),
    .ringSound(ringSound),
    .lapIndex(lapIndex)
  );

  assign strobes = {timerLoad, timerClear, lapStore, lapClear, clockSetLoad, alarmLoad};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (lapStore) n_store++;
    if (timerLoad) n_tload++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 2'd0; m_timer = TM_IDLE; m_sw = SW_IDLE;
    m_lap = 0; m_lap_strobe = 0; m_armed = 1'b0; m_ring = 1'b0;
  endfunction

  // strobe bits: {timerLoad,timerClear,lapStore,lapClear,clockSetLoad,alarmLoad}
  function automatic logic [5:0] model_press(input logic sp, input logic st, input logic md);
    logic [5:0] s;
    s = '0;
    m_lap_strobe = m_lap;
    if (m_ring) begin
      if (sp | st | md) m_ring = 1'b0;
      return s;
    end
    if (sp) begin
      if (m_mode == 2'd0) begin
        s[4] = 1'b1; m_timer = TM_IDLE;
      end else if (m_mode == 2'd1) begin
        if (m_sw == SW_RUN) begin
          s[3] = 1'b1;
          if (m_lap < LAPS - 1) m_lap++;
        end else if (m_sw == SW_STOP) begin
          s[2] = 1'b1; m_lap = 0; m_lap_strobe = 0; m_sw = SW_IDLE;
        end
      end else if (m_mode == 2'd3) begin
        s[0] = 1'b1;
      end
    end else if (st) begin
      if (m_mode == 2'd0) begin
        if (m_timer == TM_IDLE) s[5] = 1'b1;
        m_timer = (m_timer == TM_RUN) ? TM_PAUSE : TM_RUN;
      end else if (m_mode == 2'd1) begin
        m_sw = (m_sw == SW_RUN) ? SW_STOP : SW_RUN;
      end else if (m_mode == 2'd2) begin
        s[1] = 1'b1;
      end else begin
        m_armed = ~m_armed;
      end
    end else if (md) begin
      m_mode = m_mode + 2'd1;
    end
    return s;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_mode"}, 32'(mode), 32'(m_mode));
    chk({tag, "_trun"}, 32'(timerRun), 32'(m_timer == TM_RUN));
    chk({tag, "_srun"}, 32'(stopwatchRun), 32'(m_sw == SW_RUN));
    chk({tag, "_armed"}, 32'(alarmArmed), 32'(m_armed));
    chk({tag, "_ring"}, 32'(ringSound), 32'(m_ring));
    chk({tag, "_lap"}, 32'(lapIndex), 32'(m_lap_strobe));
  endtask

  // m = {split,start,mode}; hold = extra cycles kept high after the strobe cycle
  task automatic do_press(input string tag, input logic [2:0] m, input int hold);
    logic [5:0] e;
    {b_split, b_start, b_mode} = m;
    tick(LAT - 1);
    chk({tag, "_early"}, {24'd0, strobes, mode}, {24'd0, 6'd0, m_mode});
    tick(1);
    e = model_press(m[2], m[1], m[0]);
    chk({tag, "_stb"}, 32'(strobes), 32'(e));
    chk_state(tag);
    tick(1);
    m_lap_strobe = m_lap;
    chk({tag, "_width"}, 32'(strobes), 32'd0);
    chk({tag, "_lapnext"}, 32'(lapIndex), 32'(m_lap));
    tick(hold);
    {b_split, b_start, b_mode} = 3'b000;
    tick(LAT + 2);
    chk({tag, "_once"}, 32'(mode), 32'(m_mode));
  endtask

  initial begin
    int n0;
    model_reset();
    tick(2);
    chk({"reset", "_stb"}, 32'(strobes), 32'd0);
    chk_state("reset");
    rst = 1'b0;
    tick(1);

    // mode stepping, 10-cycle holds
    for (int i = 0; i < 4; i++) do_press("mode_step", 3'b001, 10 - LAT - 1);

    // timer: load/run, pause, resume
    do_press("t_start", 3'b010, int'($urandom_range(0, 3)));
    do_press("t_pause", 3'b010, int'($urandom_range(0, 3)));
    do_press("t_resume", 3'b010, int'($urandom_range(0, 3)));

    // expiry: ring one edge after the sampling edge, then full timeout
    t_exp = 1'b1;
    tick(1);
    chk("exp_lat_ring", 32'(ringSound), 32'd0);
    chk("exp_lat_trun", 32'(timerRun), 32'd1);
    tick(1);
    m_timer = TM_IDLE; m_ring = 1'b1;
    chk_state("expire");
    t_exp = 1'b0;
    tick(RINGC - 1);
    chk("ring_hold", 32'(ringSound), 32'd1);
    tick(1);
    m_ring = 1'b0;
    chk("ring_timeout", 32'(ringSound), 32'(m_ring));

    // stopwatch laps with saturation, then stop and clear
    do_press("sw_mode", 3'b001, 1);
    do_press("sw_start", 3'b010, 1);
    n0 = n_store;
    for (int i = 0; i < 51; i++) do_press("lap", 3'b100, int'($urandom_range(0, 2)));
    chk("lap_pulses", 32'(n_store - n0), 32'd51);
    chk("lap_sat", 32'(lapIndex), 32'(LAPS - 1));
    do_press("sw_stop", 3'b010, 1);
    do_press("sw_clear", 3'b100, 1);

    // back to mode 0, run timer, then simultaneous presses
    for (int i = 0; i < 3; i++) do_press("to_timer", 3'b001, 0);
    do_press("t_run2", 3'b010, 1);
    do_press("simul", 3'b111, 2);

    // single-cycle glitch on start
    n0 = n_tload;
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    tick(LAT + 4);
`ifdef TIMER_DEBOUNCE_EN
    chk("glitch_loads", 32'(n_tload - n0), 32'd0);
`else
    void'(model_press(1'b0, 1'b1, 1'b0));
    chk("glitch_loads", 32'(n_tload - n0), 32'd1);
`endif
    chk("glitch_trun", 32'(timerRun), 32'(m_timer == TM_RUN));

    // alarm: arm, ring from another mode, silence with mode press
    for (int i = 0; i < 3; i++) do_press("to_alarm", 3'b001, 0);
    do_press("arm", 3'b010, 1);
    do_press("to_sw", 3'b001, 0);
    do_press("to_sw", 3'b001, 0);
    a_match = 1'b1;
    tick(1);
    chk("match_lat", 32'(ringSound), 32'd0);
    a_match = 1'b0;
    tick(1);
    m_ring = 1'b1;
    chk_state("alarm_ring");
    do_press("silence", 3'b001, 1);

    // reset mid-ring with a press partially through conditioning
    a_match = 1'b1;
    tick(1);
    a_match = 1'b0;
    tick(1);
    chk("ring2", 32'(ringSound), 32'd1);
    b_start = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(1);
    model_reset();
    chk({"midreset", "_stb"}, 32'(strobes), 32'd0);
    chk_state("midreset");
    rst = 1'b0;
    b_start = 1'b0;
    tick(LAT + 3);
    chk_state("post_reset");

    // random press mix against the model
    for (int i = 0; i < 40; i++)
      do_press("rnd", 3'($urandom_range(1, 7)), int'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
